// File: rtl/reg_file_bypass.sv
// ---------------------------------------------------------------------------
// reg_file_bypass
//   16-entry x DATA_W general-purpose register file for the WISC datapath.
//   Two combinational read ports, one synchronous write port, and a
//   write-to-read bypass so writeback data is visible in the same cycle.
//
// Parameters
//   DATA_W   register / data port width
//   ZERO_R0  1: register 0 ignores writes and always reads zero (bypass too)
//
// Ports
//   clk       in   system clock, state updates on rising edge
//   rst       in   asynchronous active-high reset (clears all registers)
//   SrcReg1   in   [3:0]        read port 1 register ID
//   SrcReg2   in   [3:0]        read port 2 register ID
//   DstReg    in   [3:0]        write port register ID
//   WriteReg  in                write enable
//   DstData   in   [DATA_W-1:0] write data
//   SrcData1  out  [DATA_W-1:0] read port 1 data
//   SrcData2  out  [DATA_W-1:0] read port 2 data
// ---------------------------------------------------------------------------
module reg_file_bypass #(
    parameter int DATA_W  = 16,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        SrcReg1,
    input  logic [3:0]        SrcReg2,
    input  logic [3:0]        DstReg,
    input  logic              WriteReg,
    input  logic [DATA_W-1:0] DstData,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2
);

    logic [15:0]       rd1_wl_s;
    logic [15:0]       rd2_wl_s;
    logic [15:0]       wr_wl_s;
    logic [15:0]       wr_en_s;
    logic [DATA_W-1:0] regs_d [16];
    logic [DATA_W-1:0] regs_q [16];
    logic [DATA_W-1:0] rd1_or_s;
    logic [DATA_W-1:0] rd2_or_s;
    logic              dst_is_r0_s;
    logic              byp1_s;
    logic              byp2_s;

    // One-hot wordline decoders for both read ports and the write port.
    always_comb begin
        rd1_wl_s = 16'h0001 << SrcReg1;
        rd2_wl_s = 16'h0001 << SrcReg2;
        wr_wl_s  = 16'h0001 << DstReg;
    end

    // Per-register write enables and next-state values; register 0 is
    // write-protected when it is hardwired to zero.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            wr_en_s[i] = WriteReg & wr_wl_s[i];
            if (ZERO_R0 && (i == 0)) begin
                wr_en_s[i] = 1'b0;
            end else begin
                wr_en_s[i] = WriteReg & wr_wl_s[i];
            end
            if (wr_en_s[i]) begin
                regs_d[i] = DstData;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Register storage with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read muxes as AND-OR trees over the one-hot wordlines.
    always_comb begin
        rd1_or_s = {DATA_W{1'b0}};
        rd2_or_s = {DATA_W{1'b0}};
        for (int i = 0; i < 16; i++) begin
            rd1_or_s = rd1_or_s | (regs_q[i] & {DATA_W{rd1_wl_s[i]}});
            rd2_or_s = rd2_or_s | (regs_q[i] & {DATA_W{rd2_wl_s[i]}});
        end
    end

    // Bypass detection: a live write to the register being read forwards
    // DstData, except when the target is the hardwired-zero register.
    always_comb begin
        dst_is_r0_s = ZERO_R0 && (DstReg == 4'd0);
        byp1_s      = WriteReg && !rst && !dst_is_r0_s && (DstReg == SrcReg1);
        byp2_s      = WriteReg && !rst && !dst_is_r0_s && (DstReg == SrcReg2);
    end

    // Output select: reset forces zero, then bypass, then stored data.
    always_comb begin
        if (rst) begin
            SrcData1 = {DATA_W{1'b0}};
            SrcData2 = {DATA_W{1'b0}};
        end else begin
            SrcData1 = byp1_s ? DstData : rd1_or_s;
            SrcData2 = byp2_s ? DstData : rd2_or_s;
        end
    end

endmodule
